deadlock_detect_unit: RTL

- One instance per dataflow process in the C/RTL cosim testbench.
- Detects that its process is stuck: blocked only on peers that are themselves blocked, continuously for a set number of cycles.
- Raises its bit of the deadlock vector that the deadlock report unit consumes.
- After global detection, takes part in token passing. The report unit injects a token via `origin`; units forward it one hop per cycle along blocked edges, which yields the dependence circle.

---
 rtl/deadlock_pkg.sv | 20 ++
 rtl/deadlock_stall_timer.sv | 49 ++++
 rtl/deadlock_detect_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the per-process deadlock detect unit.
package deadlock_pkg;

   localparam int unsigned HOP_CNT_W    = 8;
   localparam int unsigned MAX_PROC_NUM = 64;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_STALL,
      ST_DETECTED,
      ST_SEND,
      ST_TOKEN
   } dl_state_e;

   // Isolates the least significant set bit; zero in gives zero out.
   function automatic logic [MAX_PROC_NUM-1:0] lowest_onehot(input logic [MAX_PROC_NUM-1:0] vec);
      return vec & (~vec + MAX_PROC_NUM'(1));
   endfunction

endpackage

// File: rtl/deadlock_stall_timer.sv
// Stuck-condition compare and saturating count of consecutive, unchanged stuck cycles.
module deadlock_stall_timer
   import deadlock_pkg::*;
#(
   parameter int unsigned PROC_NUM     = 4,
   parameter int unsigned MY_PROC_ID   = 0,
   parameter int unsigned STALL_CYCLES = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] blk_vec,
   input  logic [PROC_NUM-1:0] peer_blk_vec,
   input  dl_state_e           state,
   output logic [PROC_NUM-1:0] blk_m_c,
   output logic                stuck_c,
   output logic                hold_c,
   output logic                stall_done_c
);

   localparam int unsigned          CNT_W     = $clog2(STALL_CYCLES + 1);
   localparam logic [PROC_NUM-1:0] SELF_MASK = PROC_NUM'(1) << MY_PROC_ID;

   logic [CNT_W-1:0]    cnt;
   logic [PROC_NUM-1:0] blk_prev;

   assign blk_m_c = blk_vec & ~SELF_MASK;
   assign stuck_c = (blk_m_c != '0) && ((blk_m_c & ~peer_blk_vec) == '0);
   assign hold_c  = stuck_c && (blk_m_c == blk_prev);

   // The current held cycle is the STALL_CYCLES-th consecutive stuck cycle.
   assign stall_done_c = (state == ST_STALL) && hold_c && (cnt >= CNT_W'(STALL_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         blk_prev <= '0;
      end else begin
         blk_prev <= blk_m_c;
         if ((state == ST_RUN) && stuck_c) begin
            cnt <= CNT_W'(1);
         end else if ((state == ST_STALL) && hold_c) begin
            cnt <= (cnt == CNT_W'(STALL_CYCLES)) ? cnt : cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/deadlock_detect_unit.sv
// Per-process deadlock detector and dependence-circle token forwarder.
// Optional DL_HOP_COUNT_EN adds a saturating hop_cnt of token receptions.
module deadlock_detect_unit
   import deadlock_pkg::*;
#(
   parameter int unsigned PROC_NUM     = 4,
   parameter int unsigned MY_PROC_ID   = 0,
   parameter int unsigned STALL_CYCLES = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [PROC_NUM-1:0]  blk_vec,
   input  logic [PROC_NUM-1:0]  peer_blk_vec,
   input  logic                 dl_detect_in,
   input  logic [PROC_NUM-1:0]  origin,
   input  logic [PROC_NUM-1:0]  token_in_vec,
   input  logic                 token_clear,
   output logic                 dl_out,
   output logic [PROC_NUM-1:0]  token_out_vec
`ifdef DL_HOP_COUNT_EN
   ,
   output logic [HOP_CNT_W-1:0] hop_cnt
`endif
);

   localparam logic [PROC_NUM-1:0] SELF_MASK = PROC_NUM'(1) << MY_PROC_ID;

   dl_state_e           state;
   dl_state_e           state_nxt;
   logic [PROC_NUM-1:0] blk_reg;
   logic [PROC_NUM-1:0] blk_m_c;
   logic [PROC_NUM-1:0] hop_target_c;
   logic                stuck_c;
   logic                hold_c;
   logic                stall_done_c;
   logic                dl_seen;

   deadlock_stall_timer #(
      .PROC_NUM     (PROC_NUM),
      .MY_PROC_ID   (MY_PROC_ID),
      .STALL_CYCLES (STALL_CYCLES)
   ) u_stall_timer (
      .clock        (clock),
      .reset        (reset),
      .blk_vec      (blk_vec),
      .peer_blk_vec (peer_blk_vec),
      .state        (state),
      .blk_m_c      (blk_m_c),
      .stuck_c      (stuck_c),
      .hold_c       (hold_c),
      .stall_done_c (stall_done_c)
   );

   assign hop_target_c = PROC_NUM'(lowest_onehot(MAX_PROC_NUM'(blk_reg)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_RUN;
         blk_reg <= '0;
         dl_seen <= 1'b0;
      end else begin
         state   <= state_nxt;
         dl_seen <= dl_seen | dl_detect_in;
         if (stall_done_c) begin
            blk_reg <= blk_m_c;
         end
      end
   end

   // Next state plus the combinational dl_out / token hand-off.
   always_comb begin
      state_nxt     = state;
      dl_out        = 1'b0;
      token_out_vec = '0;
      case (state)
         ST_RUN: begin
            if (stuck_c) state_nxt = ST_STALL;
         end
         ST_STALL: begin
            if (stall_done_c)  state_nxt = ST_DETECTED;
            else if (!hold_c)  state_nxt = ST_RUN;
         end
         ST_DETECTED: begin
            dl_out = !dl_detect_in;
            // A false alarm is only possible before the global flag was ever seen.
            if (!dl_detect_in && !dl_seen && !stuck_c) state_nxt = ST_RUN;
            else if (|token_in_vec)                    state_nxt = ST_TOKEN;
            else if ((origin & SELF_MASK) != '0)       state_nxt = ST_SEND;
         end
         ST_SEND: begin
            token_out_vec = token_clear ? '0 : hop_target_c;
            state_nxt     = ST_DETECTED;
         end
         ST_TOKEN: begin
            dl_out        = 1'b1;
            token_out_vec = token_clear ? '0 : hop_target_c;
            state_nxt     = ST_DETECTED;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

`ifdef DL_HOP_COUNT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hop_cnt <= '0;
      end else if ((state != ST_TOKEN) && (state_nxt == ST_TOKEN) && (hop_cnt != '1)) begin
         hop_cnt <= hop_cnt + HOP_CNT_W'(1);
      end
   end
`endif

endmodule
